i2c_mem_responder: RTL and testbench

Bus-side I2C target that sits between the serial scl/sda bus and the `Memory` block. Decodes START/STOP framing, a read/write command bit and a word address, then either writes one received data word into memory or fetches a word from memory and shifts it back to the initiator on sda. It complements the existing I2C initiator and gives the design a full serial read path.

---
 rtl/i2c_mem_responder.sv | 275 +++++++++++++++++++++++++++
 tb/tb_i2c_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mem_responder.sv
// I2C target that decodes START/STOP, R/W and a word address, then writes or reads one memory word.
// Optional feature macro: I2C_RESP_AUTOINC_EN (multi-word transfers with address auto-increment).
module i2c_mem_responder #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl,
  inout  wire                  sda,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  input  logic                 mem_rdata_valid,
  output logic                 busy
);

  localparam int CNTW = $clog2(((DATAWIDTH > ADDRWIDTH) ? DATAWIDTH : ADDRWIDTH) + 1);

`ifdef I2C_RESP_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CMD      = 4'd1,
    S_ADDR     = 4'd2,
    S_ADDR_ACK = 4'd3,
    S_WDATA    = 4'd4,
    S_WACK     = 4'd5,
    S_RDATA    = 4'd6,
    S_RACK     = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  logic r_scl_s1, r_scl_s2, r_scl_q;
  logic r_sda_s1, r_sda_s2, r_sda_q;

  state_t               r_state, w_state_nxt;
  logic [CNTW-1:0]      r_cnt, w_cnt_nxt;
  logic                 r_rw, w_rw_nxt;
  logic [ADDRWIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATAWIDTH-1:0] r_data, w_data_nxt;
  logic [DATAWIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                 r_rvalid, w_rvalid_nxt;
  logic                 r_rd_wait, w_rd_wait_nxt;
  logic                 r_sda_low, w_sda_low_nxt;
  logic                 r_wr_pend, w_wr_pend_nxt;
  logic                 r_rd_pend, w_rd_pend_nxt;

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  assign sda       = r_sda_low ? 1'b0 : 1'bz;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_data;

  // Synchronizers resolve to the idle-bus level so reset release never looks like a START.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_q  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_q  <= 1'b1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_q  <= r_scl_s2;
      r_sda_s1 <= sda;
      r_sda_s2 <= r_sda_s1;
      r_sda_q  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_q;
  assign w_scl_fall = ~r_scl_s2 & r_scl_q;
  assign w_start    = r_sda_q & ~r_sda_s2 & r_scl_s2 & r_scl_q;
  assign w_stop     = ~r_sda_q & r_sda_s2 & r_scl_s2 & r_scl_q;

  // State and datapath registers; strobes fire one cycle after their pending flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= {CNTW{1'b0}};
      r_rw      <= 1'b0;
      r_addr    <= {ADDRWIDTH{1'b0}};
      r_data    <= {DATAWIDTH{1'b0}};
      r_rdata   <= {DATAWIDTH{1'b0}};
      r_rvalid  <= 1'b0;
      r_rd_wait <= 1'b0;
      r_sda_low <= 1'b0;
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rw      <= w_rw_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rd_wait <= w_rd_wait_nxt;
      r_sda_low <= w_sda_low_nxt;
      r_wr_pend <= w_wr_pend_nxt;
      r_rd_pend <= w_rd_pend_nxt;
      mem_wr_en <= r_wr_pend & ~w_stop & ~w_start;
      mem_rd_en <= r_rd_pend & ~w_stop & ~w_start;
      busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state logic: bits are sampled on scl rise, sda is only changed on scl fall.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rw_nxt      = r_rw;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_rdata_nxt   = r_rdata;
    w_rvalid_nxt  = r_rvalid;
    w_rd_wait_nxt = r_rd_wait;
    w_sda_low_nxt = r_sda_low;
    w_wr_pend_nxt = 1'b0;
    w_rd_pend_nxt = 1'b0;

    if (r_rd_pend) begin
      w_rd_wait_nxt = 1'b1;
      w_rvalid_nxt  = 1'b0;
    end else if (r_rd_wait && mem_rdata_valid) begin
      w_rdata_nxt   = mem_rdata;
      w_rvalid_nxt  = 1'b1;
      w_rd_wait_nxt = 1'b0;
    end else begin
      w_rd_wait_nxt = r_rd_wait;
    end

    if (w_stop) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = {CNTW{1'b0}};
      w_sda_low_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = S_CMD;
      w_cnt_nxt     = {CNTW{1'b0}};
      w_sda_low_nxt = 1'b0;
    end else begin
      case (r_state)
        S_CMD: begin
          if (w_scl_rise) begin
            w_rw_nxt    = r_sda_s2;
            w_state_nxt = S_ADDR;
            w_cnt_nxt   = {CNTW{1'b0}};
          end else begin
            w_rw_nxt = r_rw;
          end
        end
        S_ADDR: begin
          if (w_scl_rise) begin
            w_addr_nxt = {r_addr[ADDRWIDTH-2:0], r_sda_s2};
            if (r_cnt == CNTW'(ADDRWIDTH - 1)) begin
              w_state_nxt   = S_ADDR_ACK;
              w_cnt_nxt     = {CNTW{1'b0}};
              w_rd_pend_nxt = r_rw;
            end else begin
              w_cnt_nxt = r_cnt + CNTW'(1);
            end
          end else begin
            w_addr_nxt = r_addr;
          end
        end
        S_ADDR_ACK: begin
          // cnt 0: opening fall of the ACK slot; cnt 1: closing fall.
          if (w_scl_fall) begin
            if (r_cnt == {CNTW{1'b0}}) begin
              if (!r_rw || r_rvalid) begin
                w_sda_low_nxt = 1'b1;
                w_cnt_nxt     = CNTW'(1);
              end else begin
                w_sda_low_nxt = 1'b0;
                w_state_nxt   = S_DONE;
              end
            end else if (r_rw) begin
              w_state_nxt   = S_RDATA;
              w_sda_low_nxt = ~r_rdata[DATAWIDTH-1];
              w_rdata_nxt   = {r_rdata[DATAWIDTH-2:0], 1'b0};
              w_cnt_nxt     = CNTW'(1);
            end else begin
              w_state_nxt   = S_WDATA;
              w_sda_low_nxt = 1'b0;
              w_cnt_nxt     = {CNTW{1'b0}};
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        S_WDATA: begin
          if (w_scl_rise) begin
            w_data_nxt = {r_data[DATAWIDTH-2:0], r_sda_s2};
            if (r_cnt == CNTW'(DATAWIDTH - 1)) begin
              w_state_nxt   = S_WACK;
              w_cnt_nxt     = {CNTW{1'b0}};
              w_wr_pend_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNTW'(1);
            end
          end else begin
            w_data_nxt = r_data;
          end
        end
        S_WACK: begin
          if (w_scl_fall) begin
            if (r_cnt == {CNTW{1'b0}}) begin
              w_sda_low_nxt = 1'b1;
              w_cnt_nxt     = CNTW'(1);
            end else if (AUTOINC) begin
              w_sda_low_nxt = 1'b0;
              w_state_nxt   = S_WDATA;
              w_addr_nxt    = r_addr + ADDRWIDTH'(1);
              w_cnt_nxt     = {CNTW{1'b0}};
            end else begin
              w_sda_low_nxt = 1'b0;
              w_state_nxt   = S_DONE;
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        S_RDATA: begin
          if (w_scl_fall) begin
            if (r_cnt == CNTW'(DATAWIDTH)) begin
              w_sda_low_nxt = 1'b0;
              w_state_nxt   = S_RACK;
              w_cnt_nxt     = {CNTW{1'b0}};
            end else begin
              w_sda_low_nxt = ~r_rdata[DATAWIDTH-1];
              w_rdata_nxt   = {r_rdata[DATAWIDTH-2:0], 1'b0};
              w_cnt_nxt     = r_cnt + CNTW'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        S_RACK: begin
          if (w_scl_rise) begin
            if (AUTOINC && !r_sda_s2) begin
              w_addr_nxt    = r_addr + ADDRWIDTH'(1);
              w_rd_pend_nxt = 1'b1;
              w_state_nxt   = S_RDATA;
              w_cnt_nxt     = {CNTW{1'b0}};
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_IDLE, S_DONE: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_sda_low_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_mem_responder.sv
// Directed bench for i2c_mem_responder: bit-banged initiator, behavioral memory, strobe monitor.
module tb_i2c_mem_responder;

  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          scl = 1'b1;
  logic          sda_low = 1'b0;
  wire           sda;
  logic          mem_wr_en, mem_rd_en, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 8'h00;
  logic          mem_rdata_valid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rise = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  int wr_lat = 0, rd_lat = 0;
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [7:0] rd_addr_q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          withhold = 1'b0;
  logic          rd_pend_tb = 1'b0;
  logic [AW-1:0] rd_pend_addr = 6'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup pu_sda (sda);

  i2c_mem_responder #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .busy(busy)
  );

  // Memory with 1-clk read latency, plus a log of every strobe seen.
  always @(negedge clk) begin
    mem_rdata_valid = 1'b0;
    if (rd_pend_tb) begin
      mem_rdata       = mem[rd_pend_addr];
      mem_rdata_valid = 1'b1;
      rd_pend_tb      = 1'b0;
    end
    if (mem_wr_en) begin
      mem[mem_addr] = mem_wdata;
      wr_cnt++;
      wr_addr_q.push_back({2'b00, mem_addr});
      wr_data_q.push_back(mem_wdata);
      wr_lat = cyc - last_rise;
    end
    if (mem_rd_en) begin
      rd_cnt++;
      rd_addr_q.push_back({2'b00, mem_addr});
      rd_lat = cyc - last_rise;
      if (!withhold) begin
        rd_pend_tb   = 1'b1;
        rd_pend_addr = mem_addr;
      end
    end
    if (mem_wr_en && mem_rd_en) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start(input bit chk_busy);
    if (scl == 1'b0) begin
      tick(2); sda_low = 1'b0; tick(6); scl = 1'b1; tick(6);
    end else begin
      tick(4);
    end
    sda_low = 1'b1;
    if (chk_busy) begin
      tick(2); chk("busy_before_start_latency", {31'd0, busy}, 32'd0);
      tick(1); chk("busy_after_start", {31'd0, busy}, 32'd1);
      tick(5);
    end else begin
      tick(8);
    end
    scl = 1'b0;
  endtask

  task automatic i2c_stop(input bit chk_busy);
    tick(2); sda_low = 1'b1; tick(6); scl = 1'b1; tick(6);
    sda_low = 1'b0;
    if (chk_busy) begin
      tick(2); chk("busy_before_stop_latency", {31'd0, busy}, 32'd1);
      tick(1); chk("busy_after_stop", {31'd0, busy}, 32'd0);
      tick(5);
    end else begin
      tick(8);
    end
  endtask

  task automatic send_bit(input logic b);
    tick(2); sda_low = ~b; tick(6);
    scl = 1'b1; last_rise = cyc; tick(8);
    scl = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic recv_bit(output logic b);
    tick(2); sda_low = 1'b0; tick(6);
    scl = 1'b1; last_rise = cyc; tick(4);
    b = sda; tick(4);
    scl = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      v = {v[6:0], b};
    end
  endtask

  initial begin
    logic       a0, a1;
    logic [7:0] b0, b1, b2;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[6'h2A] = 8'h3C;
    mem[6'h3F] = 8'h81;
    mem[6'h00] = 8'h42;
    mem[6'h01] = 8'hE7;

    tick(5);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_addr", {26'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    reset = 1'b1;
    tick(5);

    // Write 0xA5 to 0x15
    i2c_start(1'b1);
    send_bit(1'b0); send_bits(8'h15, 6); recv_bit(a0);
    send_bits(8'hA5, 8); recv_bit(a1);
    i2c_stop(1'b1);
    chk("wr_addr_ack", {31'd0, a0}, 32'd0);
    chk("wr_data_ack", {31'd0, a1}, 32'd0);
    chk("wr_count", wr_cnt, 32'd1);
    chk("wr_addr", {24'd0, wr_addr_q[0]}, 32'h15);
    chk("wr_data", {24'd0, wr_data_q[0]}, 32'hA5);
    chk("wr_latency", wr_lat, 32'd4);
    chk("wr_mem", {24'd0, mem[6'h15]}, 32'hA5);
    chk("wr_no_read", rd_cnt, 32'd0);

    // Read 0x2A -> 0x3C
    i2c_start(1'b0);
    send_bit(1'b1); send_bits(8'h2A, 6); recv_bit(a0);
    recv_byte(b0); send_bit(1'b1);
    i2c_stop(1'b1);
    chk("rd_ack", {31'd0, a0}, 32'd0);
    chk("rd_count", rd_cnt, 32'd1);
    chk("rd_addr", {24'd0, rd_addr_q[0]}, 32'h2A);
    chk("rd_latency", rd_lat, 32'd4);
    chk("rd_byte", {24'd0, b0}, 32'h3C);

    // Read with valid withheld: NACK, nothing driven
    withhold = 1'b1;
    i2c_start(1'b0);
    send_bit(1'b1); send_bits(8'h10, 6); recv_bit(a0);
    recv_byte(b0); send_bit(1'b1);
    i2c_stop(1'b1);
    withhold = 1'b0;
    chk("nack_ack_slot", {31'd0, a0}, 32'd1);
    chk("nack_byte_released", {24'd0, b0}, 32'hFF);
    chk("nack_rd_count", rd_cnt, 32'd2);
    chk("nack_rd_addr", {24'd0, rd_addr_q[1]}, 32'h10);
    chk("nack_idle_busy", {31'd0, busy}, 32'd0);

    // STOP after 3 address bits
    i2c_start(1'b0);
    send_bit(1'b0); send_bits(8'h02, 3);
    i2c_stop(1'b1);
    chk("abort_wr_count", wr_cnt, 32'd1);
    chk("abort_rd_count", rd_cnt, 32'd2);
    chk("abort_sda", {31'd0, sda}, 32'd1);

    // Reset in the middle of a write data byte
    i2c_start(1'b0);
    send_bit(1'b0); send_bits(8'h07, 6); recv_bit(a0);
    send_bits(8'h0C, 4);
    sda_low = 1'b0;
    tick(1); reset = 1'b0; tick(2);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_sda", {31'd0, sda}, 32'd1);
    chk("midrst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    reset = 1'b1; tick(2);
    send_bits(8'h03, 4); recv_bit(a1);
    i2c_stop(1'b0);
    chk("midrst_pre_ack", {31'd0, a0}, 32'd0);
    chk("midrst_ignored_ack", {31'd0, a1}, 32'd1);
    chk("midrst_wr_count", wr_cnt, 32'd1);
    chk("midrst_busy_after", {31'd0, busy}, 32'd0);

    // Next full frame completes
    i2c_start(1'b1);
    send_bit(1'b0); send_bits(8'h07, 6); recv_bit(a0);
    send_bits(8'h5A, 8); recv_bit(a1);
    i2c_stop(1'b1);
    chk("recover_acks", {30'd0, a0, a1}, 32'd0);
    chk("recover_wr_count", wr_cnt, 32'd2);
    chk("recover_wr_addr", {24'd0, wr_addr_q[1]}, 32'h07);
    chk("recover_wr_data", {24'd0, wr_data_q[1]}, 32'h5A);

    // Write address, repeated START, then read from 0x3F
    i2c_start(1'b0);
    send_bit(1'b0); send_bits(8'h12, 6); recv_bit(a0);
    i2c_start(1'b0);
    send_bit(1'b1); send_bits(8'h3F, 6); recv_bit(a1);
    recv_byte(b0); send_bit(1'b0);
    recv_byte(b1); send_bit(1'b0);
    recv_byte(b2); send_bit(1'b1);
    i2c_stop(1'b1);
    chk("rs_wr_ack", {31'd0, a0}, 32'd0);
    chk("rs_rd_ack", {31'd0, a1}, 32'd0);
    chk("rs_no_write", wr_cnt, 32'd2);
    chk("rs_rd_addr0", {24'd0, rd_addr_q[2]}, 32'h3F);
    chk("rs_byte0", {24'd0, b0}, 32'h81);
`ifdef I2C_RESP_AUTOINC_EN
    chk("rs_rd_count", rd_cnt, 32'd5);
    chk("rs_rd_addr1", {24'd0, rd_addr_q[3]}, 32'h00);
    chk("rs_rd_addr2", {24'd0, rd_addr_q[4]}, 32'h01);
    chk("rs_byte1", {24'd0, b1}, 32'h42);
    chk("rs_byte2", {24'd0, b2}, 32'hE7);
`else
    chk("rs_rd_count", rd_cnt, 32'd3);
    chk("rs_byte1", {24'd0, b1}, 32'hFF);
    chk("rs_byte2", {24'd0, b2}, 32'hFF);
`endif
    chk("strobe_exclusive", both_cnt, 32'd0);
    chk("final_sda", {31'd0, sda}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
